// File: rtl/sram_arbiter.sv
// Round-robin arbiter and access sequencer for a 16-bit asynchronous SRAM shared by the CPU
// port and the loader/debug port. Every pin-facing output is driven straight from a flop.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_be,
  input  logic [19:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [1:0]  ldr_be,
  input  logic [19:0] ldr_addr,
  input  logic [15:0] ldr_wdata,
  output logic [15:0] ldr_rdata,
  output logic        ldr_ack,
  output logic [19:0] A,
  input  logic [15:0] Data_in,
  output logic [15:0] Data_out,
  output logic        Data_oe,
  output logic        CE_N,
  output logic        OE_N,
  output logic        WE_N,
  output logic        UB_N,
  output logic        LB_N
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e      state_q, state_d;
  logic        gnt_ldr_q, gnt_ldr_d;
  logic        last_ldr_q, last_ldr_d;
  logic        we_q, we_d;
  logic [1:0]  be_q, be_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] a_d;
  logic [15:0] data_out_d, cpu_rdata_d, ldr_rdata_d, rd_word;
  logic        data_oe_d, ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, cpu_ack_d, ldr_ack_d;

  logic        pick_ldr, sel_we;
  logic [1:0]  sel_be;
  logic [19:0] sel_addr;
  logic [15:0] sel_wdata;

  // On a tie the port that was not granted last wins.
  assign pick_ldr  = ldr_req & (~cpu_req | ~last_ldr_q);
  assign sel_we    = pick_ldr ? ldr_we    : cpu_we;
  assign sel_be    = pick_ldr ? ldr_be    : cpu_be;
  assign sel_addr  = pick_ldr ? ldr_addr  : cpu_addr;
  assign sel_wdata = pick_ldr ? ldr_wdata : cpu_wdata;
  assign rd_word   = Data_in & {{8{be_q[1]}}, {8{be_q[0]}}};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= StIdle;
      gnt_ldr_q  <= 1'b0;
      last_ldr_q <= 1'b1;
      we_q       <= 1'b0;
      be_q       <= 2'b00;
      cnt_q      <= 4'd0;
      A          <= '0;
      Data_out   <= '0;
      Data_oe    <= 1'b0;
      CE_N       <= 1'b1;
      OE_N       <= 1'b1;
      WE_N       <= 1'b1;
      UB_N       <= 1'b1;
      LB_N       <= 1'b1;
      cpu_ack    <= 1'b0;
      ldr_ack    <= 1'b0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_ldr_q  <= gnt_ldr_d;
      last_ldr_q <= last_ldr_d;
      we_q       <= we_d;
      be_q       <= be_d;
      cnt_q      <= cnt_d;
      A          <= a_d;
      Data_out   <= data_out_d;
      Data_oe    <= data_oe_d;
      CE_N       <= ce_n_d;
      OE_N       <= oe_n_d;
      WE_N       <= we_n_d;
      UB_N       <= ub_n_d;
      LB_N       <= lb_n_d;
      cpu_ack    <= cpu_ack_d;
      ldr_ack    <= ldr_ack_d;
      cpu_rdata  <= cpu_rdata_d;
      ldr_rdata  <= ldr_rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (cpu_req || ldr_req) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (cnt_q == 4'd0) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Computes the value each output flop takes for the state being entered.
  always_comb begin
    gnt_ldr_d   = gnt_ldr_q;
    last_ldr_d  = last_ldr_q;
    we_d        = we_q;
    be_d        = be_q;
    cnt_d       = cnt_q;
    a_d         = A;
    data_out_d  = Data_out;
    data_oe_d   = Data_oe;
    ce_n_d      = CE_N;
    oe_n_d      = OE_N;
    we_n_d      = WE_N;
    ub_n_d      = UB_N;
    lb_n_d      = LB_N;
    cpu_ack_d   = 1'b0;
    ldr_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata;
    ldr_rdata_d = ldr_rdata;
    unique case (state_q)
      StIdle: begin
        if (cpu_req || ldr_req) begin
          gnt_ldr_d  = pick_ldr;
          last_ldr_d = pick_ldr;
          we_d       = sel_we;
          be_d       = sel_be;
          cnt_d      = 4'(WAIT_CYCLES - 1);
          a_d        = sel_addr;
          ce_n_d     = (sel_be == 2'b00);
          ub_n_d     = ~sel_be[1];
          lb_n_d     = ~sel_be[0];
          oe_n_d     = 1'b1;
          we_n_d     = 1'b1;
          data_oe_d  = sel_we;
          if (sel_we) data_out_d = sel_wdata;
        end
      end
      StSetup: begin
        // A no-byte access runs the full sequence with every strobe left inactive.
        if (be_q != 2'b00) begin
          oe_n_d = we_q;
          we_n_d = ~we_q;
        end
      end
      StAccess: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ce_n_d = 1'b1;
          oe_n_d = 1'b1;
          we_n_d = 1'b1;
          ub_n_d = 1'b1;
          lb_n_d = 1'b1;
          if (gnt_ldr_q) ldr_ack_d = 1'b1;
          else           cpu_ack_d = 1'b1;
          if (!we_q) begin
            if (gnt_ldr_q) ldr_rdata_d = rd_word;
            else           cpu_rdata_d = rd_word;
          end
        end
      end
      StDone: data_oe_d = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised scoreboard bench for sram_arbiter: a transaction-level model predicts grant order,
// ack cycles and read data; a negedge monitor checks every ack and the pin protocol.
module tb_sram_arbiter;
  localparam int unsigned W = 2;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0;
  logic [1:0]  cpu_be = '0, ldr_be = '0;
  logic [19:0] cpu_addr = '0, ldr_addr = '0;
  logic [15:0] cpu_wdata = '0, ldr_wdata = '0;
  logic [15:0] cpu_rdata, ldr_rdata, Data_in = '0, Data_out;
  logic        cpu_ack, ldr_ack, Data_oe, CE_N, OE_N, WE_N, UB_N, LB_N;
  logic [19:0] A;

  // Second instance with the longest legal wait count.
  logic        r15_req = 1'b0, r15_ack, r15_lack, r15_oe, r15_ce_n, r15_oe_n, r15_we_n;
  logic        r15_ub_n, r15_lb_n;
  logic [19:0] r15_a;
  logic [15:0] r15_rdata, r15_lrdata, r15_dout, r15_din = '0;
  logic        zero1 = 1'b0;
  logic [1:0]  zero2 = '0;
  logic [19:0] zero20 = '0;
  logic [15:0] zero16 = '0;

  always #5 Clk = ~Clk;

  sram_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_be(ldr_be), .ldr_addr(ldr_addr),
    .ldr_wdata(ldr_wdata), .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
    .A(A), .Data_in(Data_in), .Data_out(Data_out), .Data_oe(Data_oe),
    .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N)
  );

  sram_arbiter #(.WAIT_CYCLES(15)) u_dut15 (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(r15_req), .cpu_we(zero1), .cpu_be(2'b11), .cpu_addr(20'h00005),
    .cpu_wdata(zero16), .cpu_rdata(r15_rdata), .cpu_ack(r15_ack),
    .ldr_req(zero1), .ldr_we(zero1), .ldr_be(zero2), .ldr_addr(zero20),
    .ldr_wdata(zero16), .ldr_rdata(r15_lrdata), .ldr_ack(r15_lack),
    .A(r15_a), .Data_in(r15_din), .Data_out(r15_dout), .Data_oe(r15_oe),
    .CE_N(r15_ce_n), .OE_N(r15_oe_n), .WE_N(r15_we_n), .UB_N(r15_ub_n), .LB_N(r15_lb_n)
  );

  typedef struct {
    bit          ldr;
    bit          we;
    logic [1:0]  be;
    logic [19:0] addr;
    logic [15:0] wdata;
  } txn_t;

  typedef struct {
    bit          ldr;
    bit          we;
    logic [1:0]  be;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int unsigned at;
    int unsigned strobes;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  txn_t        cpu_q[$], ldr_q[$];
  exp_t        sb[$];
  bit          m_last_ldr = 1'b1;
  logic [15:0] m_rdata [0:1];
  logic [15:0] ref_mem [logic [19:0]];
  logic [15:0] sram    [logic [19:0]];

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_word(input logic [19:0] a);
    return a[15:0] ^ {a[19:16], 12'h5A3};
  endfunction

  function automatic txn_t mk(input bit ldr, input bit we, input logic [1:0] be,
                              input logic [19:0] addr, input logic [15:0] wdata);
    txn_t t;
    t.ldr = ldr; t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rand_txn(input bit ldr);
    return mk(ldr, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
              20'($urandom_range(0, 7)) | (20'($urandom_range(0, 1)) << 19), 16'($urandom));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: applies one access to the reference memory and queues the
  // response the monitor must see.
  function automatic void push_expected(input txn_t t, input int unsigned at);
    exp_t        e;
    logic [15:0] w, m;
    w = ref_mem.exists(t.addr) ? ref_mem[t.addr] : init_word(t.addr);
    m = {{8{t.be[1]}}, {8{t.be[0]}}};
    if (t.we) ref_mem[t.addr] = (w & ~m) | (t.wdata & m);
    else      m_rdata[int'(t.ldr)] = w & m;
    e.ldr = t.ldr; e.we = t.we; e.be = t.be; e.addr = t.addr; e.wdata = t.wdata;
    e.rdata   = m_rdata[int'(t.ldr)];
    e.at      = at;
    e.strobes = (t.be != 2'b00) ? W : 0;
    sb.push_back(e);
  endfunction

  task automatic present_cpu();
    if (cpu_q.size() > 0) begin
      cpu_req = 1'b1; cpu_we = cpu_q[0].we; cpu_be = cpu_q[0].be;
      cpu_addr = cpu_q[0].addr; cpu_wdata = cpu_q[0].wdata;
    end else cpu_req = 1'b0;
  endtask

  task automatic present_ldr();
    if (ldr_q.size() > 0) begin
      ldr_req = 1'b1; ldr_we = ldr_q[0].we; ldr_be = ldr_q[0].be;
      ldr_addr = ldr_q[0].addr; ldr_wdata = ldr_q[0].wdata;
    end else ldr_req = 1'b0;
  endtask

  // Both ports present their whole queues back to back; each completed access is replaced by
  // the port's next one in the cycle after its ack.
  task automatic run_burst();
    txn_t        cq[$], lq[$], t;
    int unsigned c0, k, budget, n;
    bit          pick;
    cq = cpu_q; lq = ldr_q;
    @(negedge Clk);
    c0 = cyc; k = 0;
    while (cq.size() > 0 || lq.size() > 0) begin
      pick = (lq.size() > 0) && (cq.size() == 0 || !m_last_ldr);
      if (pick) begin t = lq[0]; lq.delete(0); end
      else      begin t = cq[0]; cq.delete(0); end
      m_last_ldr = pick;
      push_expected(t, c0 + W + 2 + k * (W + 3));
      k++;
    end
    present_cpu();
    present_ldr();
    budget = k * (W + 3) + 10;
    n = 0;
    while ((cpu_q.size() > 0 || ldr_q.size() > 0) && n < budget) begin
      @(negedge Clk);
      n++;
      if (cpu_ack && cpu_q.size() > 0) begin cpu_q.delete(0); present_cpu(); end
      if (ldr_ack && ldr_q.size() > 0) begin ldr_q.delete(0); present_ldr(); end
    end
    if (cpu_q.size() > 0 || ldr_q.size() > 0) begin
      errors++;
      $display("FAIL burst_timeout: %0d accesses still pending after %0d cycles",
               cpu_q.size() + ldr_q.size(), n);
      cpu_q.delete(); ldr_q.delete();
    end
    cpu_req = 1'b0; ldr_req = 1'b0;
    repeat (2) @(negedge Clk);
    check("sb_drained", 32'(sb.size()), 0);
    sb.delete();
  endtask

  // SRAM pad model.
  initial begin
    logic [15:0] w;
    forever begin
      @(negedge Clk);
      Data_in = (!CE_N && !OE_N) ? (sram.exists(A) ? sram[A] : init_word(A)) : 16'hDEAD;
      if (!CE_N && !WE_N) begin
        w = sram.exists(A) ? sram[A] : init_word(A);
        if (!UB_N) w[15:8] = Data_out[15:8];
        if (!LB_N) w[7:0]  = Data_out[7:0];
        sram[A] = w;
      end
      r15_din = !r15_oe_n ? init_word(r15_a) : 16'hDEAD;
    end
  end

  // Monitor: pin protocol every cycle, scoreboard comparison on every ack.
  initial begin
    exp_t        h;
    bit          have;
    int unsigned scnt = 0, ocnt = 0;
    logic        oe_prev = 1'b0;
    forever begin
      @(negedge Clk);
      if (!Reset) begin
        scnt = 0; ocnt = 0; oe_prev = 1'b0;
      end else begin
        check("we_oe_overlap", 32'(!WE_N && !OE_N), 0);
        check("we_without_prior_oe", 32'(!WE_N && !oe_prev), 0);
        check("oe_during_read", 32'(Data_oe && !OE_N), 0);
        if (!OE_N || !WE_N) scnt++;
        if (Data_oe) ocnt++;
        have = sb.size() > 0;
        if (have) begin
          h = sb[0];
          if (!OE_N || !WE_N) begin
            check("strobe_addr", 32'(A), 32'(h.addr));
            check("strobe_ub_n", 32'(UB_N), 32'(!h.be[1]));
            check("strobe_lb_n", 32'(LB_N), 32'(!h.be[0]));
            check("strobe_kind", 32'(WE_N), 32'(!h.we));
            if (h.we) check("write_data", 32'(Data_out), 32'(h.wdata));
          end
          if (h.be == 2'b00) check("ce_n_no_bytes", 32'(CE_N), 1);
        end
        if (cpu_ack || ldr_ack) begin
          checks++;
          if (!have || (cpu_ack && ldr_ack)) begin
            errors++;
            $display("FAIL unexpected_ack: cpu_ack=%0b ldr_ack=%0b pending=%0d, expected none",
                     cpu_ack, ldr_ack, sb.size());
          end else begin
            sb.delete(0);
            check("ack_port", 32'(ldr_ack), 32'(h.ldr));
            check("ack_cycle", cyc, h.at);
            check("rdata", 32'(h.ldr ? ldr_rdata : cpu_rdata), 32'(h.rdata));
            check("strobe_cycles", scnt, h.strobes);
            check("data_oe_cycles", ocnt, h.we ? W + 2 : 0);
          end
          scnt = 0; ocnt = 0;
        end
        oe_prev = Data_oe;
      end
    end
  end

  task automatic check_idle_pins(input string tag);
    check({tag, "_a"}, 32'(A), 0);
    check({tag, "_data_out"}, 32'(Data_out), 0);
    check({tag, "_data_oe"}, 32'(Data_oe), 0);
    check({tag, "_strobes"}, 32'({CE_N, OE_N, WE_N, UB_N, LB_N}), 32'h1F);
    check({tag, "_acks"}, 32'({cpu_ack, ldr_ack}), 0);
    check({tag, "_rdata"}, {cpu_rdata, ldr_rdata}, 0);
  endtask

  task automatic reset_mid_write();
    @(negedge Clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 20'hFFFFF; cpu_wdata = 16'h1234;
    repeat (2) @(negedge Clk);
    check("pre_reset_we_n", 32'(WE_N), 0);
    #2 Reset = 1'b0;
    #1 check_idle_pins("async_reset");
    cpu_req = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    m_last_ldr = 1'b1;
    m_rdata[0] = '0; m_rdata[1] = '0;
    repeat (8) @(negedge Clk);
  endtask

  task automatic run_w15();
    int unsigned oe_low = 0, ack_at = 0, acks = 0;
    @(negedge Clk);
    r15_req = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge Clk);
      if (!r15_oe_n) oe_low++;
      if (r15_ack) begin ack_at = i; acks++; r15_req = 1'b0; end
    end
    check("w15_oe_low_cycles", oe_low, 15);
    check("w15_ack_cycle", ack_at, 17);
    check("w15_ack_count", acks, 1);
    check("w15_rdata", 32'(r15_rdata), 32'(init_word(20'h00005)));
  endtask

  initial begin
    int unsigned nc, nl;
    m_rdata[0] = '0; m_rdata[1] = '0;
    repeat (3) @(negedge Clk);
    check_idle_pins("reset");
    Reset = 1'b1;

    cpu_q.push_back(mk(1'b0, 1'b1, 2'b11, 20'h00010, 16'hBEEF)); run_burst();
    cpu_q.push_back(mk(1'b0, 1'b0, 2'b11, 20'h00010, 16'h0));    run_burst();
    cpu_q.push_back(mk(1'b0, 1'b0, 2'b01, 20'h00010, 16'h0));    run_burst();
    check("be01_rdata", 32'(cpu_rdata), 32'h00EF);

    for (int i = 0; i < 3; i++) begin
      cpu_q.push_back(rand_txn(1'b0));
      ldr_q.push_back(rand_txn(1'b1));
    end
    run_burst();

    ldr_q.push_back(mk(1'b1, 1'b1, 2'b00, 20'h00010, 16'h1111)); run_burst();
    cpu_q.push_back(mk(1'b0, 1'b0, 2'b11, 20'h00010, 16'h0));    run_burst();
    check("be00_write_ignored", 32'(cpu_rdata), 32'hBEEF);

    reset_mid_write();
    for (int i = 0; i < 2; i++) begin
      cpu_q.push_back(rand_txn(1'b0));
      ldr_q.push_back(rand_txn(1'b1));
    end
    run_burst();

    run_w15();

    repeat (40) begin
      nc = $urandom_range(0, 3);
      nl = $urandom_range(0, 3);
      for (int i = 0; i < int'(nc); i++) cpu_q.push_back(rand_txn(1'b0));
      for (int i = 0; i < int'(nl); i++) ldr_q.push_back(rand_txn(1'b1));
      if (nc + nl > 0) run_burst();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Arbitrates the single external 16-bit asynchronous SRAM between two requesters, the CPU memory port and a loader/debug port that fills or inspects memory while the CPU is halted. It sequences each access through setup, strobe, and completion phases with a programmable wait count. It drives the active-low chip strobes, the 20-bit address, and the tristate data-bus control that the top level wires to the SRAM pins. The top level instantiates it between the processor/Mem2IO path and the SRAM pins.

## Interface
- WAIT_CYCLES, 2, cycles the OE_N/WE_N strobe is held low; legal range 1..15
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_be  in  2  byte enables, [1] upper, [0] lower
- cpu_addr  in  20  word address
- cpu_wdata  in  16  write data
- cpu_rdata  out  16  read data, valid while cpu_ack = 1
- cpu_ack  out  1  one-cycle completion pulse
- ldr_req, ldr_we, ldr_be, ldr_addr, ldr_wdata, ldr_rdata, ldr_ack: same widths and meanings, loader port
- A  out  20  SRAM address
- Data_in  in  16  SRAM data bus as read from the pad
- Data_out  out  16  value driven onto the SRAM data bus
- Data_oe  out  1  1 = top level drives Data_out onto the bus
- CE_N, OE_N, WE_N, UB_N, LB_N  out  1 each  SRAM strobes, active-low

## Operation
- States: IDLE, SETUP, ACCESS, DONE.
- IDLE: samples both requests. If neither is high, stays in IDLE. Otherwise registers the grant, the address, we, be, and wdata of the winner, and goes to SETUP.
- Arbitration is round-robin. A single request is granted directly. When both are high, the port not granted last wins. After reset, last-granted = loader, so the CPU wins the first tie.
- SETUP (1 cycle): A = latched address. CE_N = 0. UB_N = ~be[1], LB_N = ~be[0]. OE_N = WE_N = 1. For a write, Data_oe = 1 and Data_out = wdata. Loads the wait counter with WAIT_CYCLES-1.
- ACCESS (WAIT_CYCLES cycles): a read holds OE_N = 0; a write holds WE_N = 0. The counter decrements each cycle. When the counter reaches 0, a read captures Data_in with unselected bytes forced to 0, then the block goes to DONE.
- DONE (1 cycle): all strobes return to 1. Data_oe stays at its SETUP value to give write hold time. The granted port's ack = 1 and its rdata holds the captured word. Next state is IDLE.
- be = 2'b00: the full state sequence still runs and ack still fires, but CE_N, OE_N, WE_N, UB_N, and LB_N all stay 1, and a read returns 16'h0000.
- Requester rule: deassert req or present a new request in the cycle after ack. A req still high in the IDLE cycle after ack counts as a new request.
- Request inputs are ignored outside IDLE. Changes to addr or wdata during a transaction have no effect.
- rdata holds its last captured value until the next read completes on that port.

## Timing
- Reset (asserted low, async, any state) forces the following immediately, mid-transaction included:
  - state = IDLE
  - A = 0, Data_out = 0, Data_oe = 0
  - CE_N = OE_N = WE_N = UB_N = LB_N = 1
  - both acks = 0, both rdata = 0
  - last-granted = loader
- An aborted transaction never acks.
- Latency: request seen in IDLE at cycle 0 → SETUP at cycle 1 → ACCESS at cycles 2..WAIT_CYCLES+1 → ack at cycle WAIT_CYCLES+2.
- Throughput: one access per WAIT_CYCLES+3 cycles, because one IDLE cycle always separates transactions.
- WE_N is never low in the same cycle as OE_N.
- WE_N is never low unless Data_oe was already 1 in the previous cycle.
- Data_oe is never 1 during a read.
- All outputs are registered; there are no combinational paths from req to the pins.

## Test plan
- Reset, then CPU writes addr 20'h00010, data 16'hBEEF, be 2'b11, WAIT_CYCLES = 2 → SETUP at cycle 1, WE_N low at cycles 2–3, cpu_ack at cycle 4, Data_oe high at cycles 1–4, UB_N = LB_N = 0.
- CPU reads 20'h00010 with the SRAM model returning 16'hBEEF → OE_N low at cycles 2–3, Data_oe = 0 throughout, cpu_ack at cycle 4 with cpu_rdata = 16'hBEEF. A read with be = 2'b01 returns 16'h00EF and drives UB_N = 1.
- Both ports request continuously after reset → grants alternate CPU, loader, CPU, loader with acks spaced 5 cycles apart (WAIT_CYCLES = 2). No ack ever goes to a port whose req is low.
- Loader write with be = 2'b00 → ldr_ack at cycle 4, all strobes stay 1, and the SRAM contents are unchanged.
- Reset asserted during the ACCESS phase of a write → strobes go to 1 and Data_oe goes to 0 without waiting for a clock edge, no ack fires, and the first access after release completes normally.
- WAIT_CYCLES = 15, a single read → OE_N low for exactly 15 cycles, ack at cycle 17.
